id_ex_reg: RTL and testbench

- ID/EX pipeline register of the P5 five-stage MIPS32 core. It sits directly downstream of the ID-stage immediate extender `ext` and register-file read.
- Latches the decoded ID bundle (instr, pc, rs/rt data, ext32, destination register, Tnew) for the EX stage.
- Supports bubble insertion (clr), freeze (hold), and Tnew aging for the hazard unit.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_reg_pkg.sv | 20 ++
 rtl/id_ex_reg_if.sv | 38 +++
 rtl/id_ex_reg_pipe_field.sv | 39 +++
 rtl/id_ex_reg.sv | 78 +++++++
 tb/tb_id_ex_reg.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared P5 core definitions used by the ID/EX register
package p5_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          TNEW_W       = 2;
    localparam int          REG_W        = 5;

    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [REG_W-1:0]  reg_num_t;

    // One cycle of aging; writes to $0 never produce a hazard.
    function automatic tnew_t tnew_age(input reg_num_t a3, input tnew_t tnew);
        if (a3 == '0 || tnew == '0) begin
            return '0;
        end
        return tnew - tnew_t'(1);
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - ID-side bundle, control and EX-side bundle of the ID/EX register
interface id_ex_reg_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) ();
    import p5_defs::*;

    logic             clr;
    logic             hold;
    logic [31:0]      instr_d;
    logic [DW-1:0]    pc_d;
    logic [DW-1:0]    rs_data_d;
    logic [DW-1:0]    rt_data_d;
    logic [DW-1:0]    ext32_d;
    reg_num_t         a3_d;
    tnew_t            tnew_d;

    logic [31:0]      instr_e;
    logic [DW-1:0]    pc_e;
    logic [DW-1:0]    rs_data_e;
    logic [DW-1:0]    rt_data_e;
    logic [DW-1:0]    ext32_e;
    reg_num_t         a3_e;
    tnew_t            tnew_e;
    logic             valid_e;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output clr, hold, instr_d, pc_d, rs_data_d, rt_data_d, ext32_d, a3_d, tnew_d,
        input  instr_e, pc_e, rs_data_e, rt_data_e, ext32_e, a3_e, tnew_e, valid_e, bubble_cnt
    );

    modport slave (
        input  clr, hold, instr_d, pc_d, rs_data_d, rt_data_d, ext32_d, a3_d, tnew_d,
        output instr_e, pc_e, rs_data_e, rt_data_e, ext32_e, a3_e, tnew_e, valid_e, bubble_cnt
    );

endinterface

// File: rtl/id_ex_reg_pipe_field.sv
// rtl/id_ex_reg_pipe_field.sv - one pipeline field flop with async reset, clear and hold
module pipe_field #(
    parameter int           W          = 32,
    parameter logic [W-1:0] RST_VAL    = '0,
    parameter logic [W-1:0] CLR_VAL    = '0,
    parameter bit           CLR_LOADS  = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // CLR_LOADS lets a field (the PC) keep flowing through a bubble.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = CLR_LOADS ? d : CLR_VAL;
        end else if (!hold) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with bubble/freeze, Tnew aging and bubble counter
module id_ex_reg
    import p5_defs::*;
#(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] RESET_PC = DW'(RESET_PC_DEF),
    parameter int            CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    id_ex_reg_if.slave   bus
);

    tnew_t            tnew_aged;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    assign tnew_aged = tnew_age(bus.a3_d, bus.tnew_d);

    pipe_field #(.W(32), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.instr_d), .q(bus.instr_e)
    );

    pipe_field #(.W(DW), .RST_VAL(RESET_PC), .CLR_VAL('0), .CLR_LOADS(1'b1)) u_pc (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.pc_d), .q(bus.pc_e)
    );

    pipe_field #(.W(DW)) u_rs (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.rs_data_d), .q(bus.rs_data_e)
    );

    pipe_field #(.W(DW)) u_rt (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.rt_data_d), .q(bus.rt_data_e)
    );

    pipe_field #(.W(DW)) u_ext (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.ext32_d), .q(bus.ext32_e)
    );

    pipe_field #(.W(REG_W)) u_a3 (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(bus.a3_d), .q(bus.a3_e)
    );

    pipe_field #(.W(TNEW_W)) u_tnew (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(tnew_aged), .q(bus.tnew_e)
    );

    pipe_field #(.W(1)) u_valid (
        .clk(clk), .reset_n(reset_n), .clr(bus.clr), .hold(bus.hold),
        .d(1'b1), .q(bus.valid_e)
    );

    // Counts every bubble, including clr during hold; sticks at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bus.clr && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.DW(32), .CNT_W(4)) bus ();

    id_ex_reg #(.DW(32), .RESET_PC(32'h0000_3000), .CNT_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext, input logic [4:0] a3,
                         input logic [1:0] tnew);
        bus.instr_d   = instr;
        bus.pc_d      = pc;
        bus.rs_data_d = rs;
        bus.rt_data_d = rt;
        bus.ext32_d   = ext;
        bus.a3_d      = a3;
        bus.tnew_d    = tnew;
    endtask

    logic [1:0] tnew_in  [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [1:0] tnew_exp [4] = '{2'd1, 2'd0, 2'd0, 2'd2};

    initial begin
        reset_n  = 1'b0;
        bus.clr  = 1'b0;
        bus.hold = 1'b0;
        drive('0, '0, '0, '0, '0, '0, '0);
        #12 reset_n = 1'b1;

        // Random traffic, then a mid-cycle reset.
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'd7, 2'd2);
        step();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'd9, 2'd3);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_instr", bus.instr_e, 32'h0);
        chk("rst_pc", bus.pc_e, 32'h0000_3000);
        chk("rst_rs", bus.rs_data_e, 32'h0);
        chk("rst_rt", bus.rt_data_e, 32'h0);
        chk("rst_ext", bus.ext32_e, 32'h0);
        chk("rst_a3", 32'(bus.a3_e), 32'h0);
        chk("rst_tnew", 32'(bus.tnew_e), 32'h0);
        chk("rst_valid", 32'(bus.valid_e), 32'h0);
        chk("rst_cnt", 32'(bus.bubble_cnt), 32'h0);
        #2 reset_n = 1'b1;

        drive(32'h3c01_1234, 32'h0000_3004, 32'h0, 32'h0, 32'h1234_0000, 5'd1, 2'd1);
        step();
        chk("lui_instr", bus.instr_e, 32'h3c01_1234);
        chk("lui_ext", bus.ext32_e, 32'h1234_0000);
        chk("lui_valid", 32'(bus.valid_e), 32'h1);
        chk("lui_pc", bus.pc_e, 32'h0000_3004);
        chk("lui_tnew", 32'(bus.tnew_e), 32'h0);

        // Tnew aging.
        for (int i = 0; i < 4; i++) begin
            drive(32'h0000_0020 + 32'(i), 32'h0000_3100, 32'h5, 32'h6, 32'h7, 5'd8, tnew_in[i]);
            step();
            chk($sformatf("tnew_age%0d", i), 32'(bus.tnew_e), 32'(tnew_exp[i]));
            chk($sformatf("tnew_a3_%0d", i), 32'(bus.a3_e), 32'd8);
        end
        drive(32'h0000_0040, 32'h0000_3104, 32'h5, 32'h6, 32'h7, 5'd0, 2'd2);
        step();
        chk("tnew_a3zero", 32'(bus.tnew_e), 32'h0);
        chk("a3zero", 32'(bus.a3_e), 32'h0);

        // Bubble.
        drive(32'hdead_beef, 32'h0000_3008, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd5, 2'd3);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("bub_instr", bus.instr_e, 32'h0);
        chk("bub_rs", bus.rs_data_e, 32'h0);
        chk("bub_rt", bus.rt_data_e, 32'h0);
        chk("bub_ext", bus.ext32_e, 32'h0);
        chk("bub_a3", 32'(bus.a3_e), 32'h0);
        chk("bub_tnew", 32'(bus.tnew_e), 32'h0);
        chk("bub_valid", 32'(bus.valid_e), 32'h0);
        chk("bub_pc", bus.pc_e, 32'h0000_3008);
        chk("bub_cnt", 32'(bus.bubble_cnt), 32'd1);

        // Hold.
        drive(32'h8c22_0004, 32'h0000_300c, 32'h1111_1111, 32'h2222_2222, 32'h0000_0004, 5'd2, 2'd2);
        step();
        chk("ld_pc", bus.pc_e, 32'h0000_300c);
        chk("ld_tnew", 32'(bus.tnew_e), 32'd1);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hffff_0000 + 32'(i), 32'h0000_4000 + 32'(i), 32'h9, 32'ha, 32'hb, 5'd31, 2'd3);
            step();
            chk($sformatf("hold_pc%0d", i), bus.pc_e, 32'h0000_300c);
            chk($sformatf("hold_instr%0d", i), bus.instr_e, 32'h8c22_0004);
            chk($sformatf("hold_rs%0d", i), bus.rs_data_e, 32'h1111_1111);
            chk($sformatf("hold_rt%0d", i), bus.rt_data_e, 32'h2222_2222);
            chk($sformatf("hold_ext%0d", i), bus.ext32_e, 32'h0000_0004);
            chk($sformatf("hold_a3_%0d", i), 32'(bus.a3_e), 32'd2);
            chk($sformatf("hold_tnew%0d", i), 32'(bus.tnew_e), 32'd1);
            chk($sformatf("hold_valid%0d", i), 32'(bus.valid_e), 32'd1);
            chk($sformatf("hold_cnt%0d", i), 32'(bus.bubble_cnt), 32'd1);
        end

        // clr and hold together: clr wins.
        drive(32'h1234_5678, 32'h0000_3010, 32'h1, 32'h2, 32'h3, 5'd4, 2'd2);
        bus.clr = 1'b1;
        step();
        bus.clr  = 1'b0;
        bus.hold = 1'b0;
        chk("ch_instr", bus.instr_e, 32'h0);
        chk("ch_valid", 32'(bus.valid_e), 32'h0);
        chk("ch_pc", bus.pc_e, 32'h0000_3010);
        chk("ch_cnt", 32'(bus.bubble_cnt), 32'd2);

        // Saturation of the 4-bit counter, starting from 2.
        bus.clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("sat_cnt%0d", i), 32'(bus.bubble_cnt), (i + 3 > 15) ? 32'd15 : 32'(i + 3));
        end
        bus.clr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("sat_rst_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("sat_rst_pc", bus.pc_e, 32'h0000_3000);
        #2 reset_n = 1'b1;

        drive(32'h2001_0005, 32'h0000_3014, 32'h7, 32'h8, 32'h5, 5'd1, 2'd3);
        step();
        chk("post_valid", 32'(bus.valid_e), 32'd1);
        chk("post_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("post_tnew", 32'(bus.tnew_e), 32'd2);
        chk("post_rt", bus.rt_data_e, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
